// File: rtl/move_replayer.sv
//------------------------------------------------------------------------------
// move_replayer: replays buffered maze moves and checks the end pose against a target.
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module move_replayer (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] targetX,
    input  logic [3:0] targetY,
    input  logic [1:0] Move,
    input  logic       moveValid,
    output logic       moveReady,
    input  logic       sqDone,
    output logic [3:0] poseX,
    output logic [3:0] poseY,
    output logic [7:0] stepCount,
    output logic       busy,
    output logic       pass,
    output logic       fail
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RUN   = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_PASS  = 3'd3;
    localparam logic [2:0] S_FAIL  = 3'd4;

    logic [2:0] state_q, state_d;
    logic       pass_q, fail_q;
    logic [1:0] fifo_q [4];
    logic [1:0] wr_q, wr_d, rd_q, rd_d;
    logic [2:0] cnt_q, cnt_d;
    logic [3:0] tx_q, tx_d, ty_q, ty_d;
    logic [3:0] posx_q, posx_d, posy_q, posy_d;
    logic [7:0] step_q, step_d;

    logic       push, pop, viol, flush, start_acc, hit;
    logic [1:0] head;
    logic [4:0] nx, ny;
    logic [2:0] cnt_after;

    // Output decode
    always_comb begin
        moveReady = (state_q == S_RUN) && (cnt_q != 3'd4) && !sqDone;
        busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
    end

    // One extra bit on the candidate pose flags both overflow past 15 and underflow below 0.
    always_comb begin
        push      = moveValid && moveReady;
        pop       = busy && (cnt_q != 3'd0);
        head      = fifo_q[rd_q];
        start_acc = start && ((state_q == S_IDLE) || (state_q == S_PASS) || (state_q == S_FAIL));
        nx        = {1'b0, posx_q};
        ny        = {1'b0, posy_q};
        case (head)
            2'b00:   nx = {1'b0, posx_q} + 5'd1;
            2'b01:   ny = {1'b0, posy_q} + 5'd1;
            2'b10:   nx = {1'b0, posx_q} - 5'd1;
            default: ny = {1'b0, posy_q} - 5'd1;
        endcase
        viol      = pop && (nx[4] || ny[4]);
        flush     = start_acc || viol;
        cnt_after = cnt_q - {2'b00, pop} + {2'b00, push};
    end

    always_comb begin
        posx_d = posx_q;
        posy_d = posy_q;
        step_d = step_q;
        tx_d   = tx_q;
        ty_d   = ty_q;
        if (start_acc) begin
            posx_d = 4'd0;
            posy_d = 4'd0;
            step_d = 8'd0;
            tx_d   = targetX;
            ty_d   = targetY;
        end else if (pop && !viol) begin
            posx_d = nx[3:0];
            posy_d = ny[3:0];
            step_d = (step_q == 8'hFF) ? step_q : step_q + 8'd1;
        end
        cnt_d = flush ? 3'd0 : cnt_after;
        wr_d  = flush ? 2'd0 : wr_q + {1'b0, push};
        rd_d  = flush ? 2'd0 : rd_q + {1'b0, pop};
        hit   = (posx_d == tx_q) && (posy_d == ty_q);
    end

    // Next-state logic; a boundary violation outranks resolution.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_PASS, S_FAIL: if (start) state_d = S_RUN;
            S_RUN: begin
                if (viol)
                    state_d = S_FAIL;
                else if (sqDone)
                    state_d = (cnt_after != 3'd0) ? S_DRAIN : (hit ? S_PASS : S_FAIL);
            end
            S_DRAIN: begin
                if (viol)
                    state_d = S_FAIL;
                else if (cnt_after == 3'd0)
                    state_d = hit ? S_PASS : S_FAIL;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pass_q  <= (state_d == S_PASS);
            fail_q  <= (state_d == S_FAIL);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) fifo_q[i] <= 2'b00;
            wr_q   <= 2'd0;
            rd_q   <= 2'd0;
            cnt_q  <= 3'd0;
            tx_q   <= 4'd0;
            ty_q   <= 4'd0;
            posx_q <= 4'd0;
            posy_q <= 4'd0;
            step_q <= 8'd0;
        end else begin
            if (push && !flush) fifo_q[wr_q] <= Move;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
            tx_q   <= tx_d;
            ty_q   <= ty_d;
            posx_q <= posx_d;
            posy_q <= posy_d;
            step_q <= step_d;
        end
    end

    assign poseX     = posx_q;
    assign poseY     = posy_q;
    assign stepCount = step_q;
    assign pass      = pass_q;
    assign fail      = fail_q;

endmodule

`default_nettype wire

// File: doc/move_replayer.md
MOVE_REPLAYER -- requirements
Module: move_replayer

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-low.
REQ-002 SHALL have the ports below, one per line: name, direction, width, meaning.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-low
- start  in  1  one-cycle pulse that begins a replay
- targetX, targetY  in  4 each  goal cell, sampled on accepted start
- Move  in  2  move code from the maze datapath queue readout
- moveValid  in  1  Move is valid this cycle
- moveReady  out  1  replayer accepts Move this cycle
- sqDone  in  1  level, no further moves will be offered
- poseX, poseY  out  4 each  replayed position
- stepCount  out  8  moves executed
- busy  out  1  state is RUN or DRAIN
- pass, fail  out  1 each  sticky result flags

Function
REQ-003 Move encoding SHALL be:
- 00: X+1
- 01: Y+1
- 10: X-1
- 11: Y-1
REQ-004 The FSM SHALL have states IDLE, RUN, DRAIN, PASS and FAIL, with IDLE as the reset state.
REQ-005 IDLE/PASS/FAIL + start SHALL transition to RUN, with these actions:
- capture targetX/targetY
- clear poseX/poseY to 0, stepCount to 0, pass/fail, and the FIFO
REQ-006 start SHALL be ignored in RUN and DRAIN.
REQ-007 The block SHALL contain a 4-entry, 2-bit FIFO holding accepted moves.
REQ-008 moveReady SHALL = (state==RUN) && !FIFO full && !sqDone, combinational.
REQ-009 A transfer SHALL occur when moveValid && moveReady at a rising edge; the move is written to the FIFO tail.
REQ-010 moveValid without moveReady SHALL cause no write; the source holds Move.
REQ-011 Execute rule: in RUN or DRAIN with FIFO non-empty, one move SHALL pop per cycle.
- poseX/poseY update at the same edge as the pop.
- Latency: a move accepted at edge N affects pose at edge N+1 at the earliest (FIFO empty case).
REQ-012 A push and a pop in the same cycle SHALL both occur; occupancy is unchanged.
REQ-013 Boundary: a popped move that would take X or Y below 0 or above 15 SHALL cause:
- pose held, no wrap-around
- stepCount not incremented
- next state FAIL, with all remaining FIFO contents discarded
REQ-014 stepCount SHALL increment by 1 per legal executed move and saturate at 255.
REQ-015 RUN SHALL transition to DRAIN when sqDone=1 and the FIFO is non-empty after this cycle's pop.
REQ-016 RUN SHALL resolve directly (REQ-017) when sqDone=1 and the FIFO will be empty.
REQ-017 Resolve rule (DRAIN with empty FIFO, or REQ-016):
- pose==target: go to PASS
- otherwise: go to FAIL
REQ-018 A boundary violation SHALL take priority over resolve in the same cycle.
REQ-019 pass SHALL be 1 exactly in state PASS; fail SHALL be 1 exactly in state FAIL.
REQ-020 poseX, poseY and stepCount SHALL hold their values in PASS, FAIL and IDLE.
REQ-021 busy SHALL = (state==RUN || state==DRAIN).
REQ-022 All outputs SHALL be registered except moveReady and busy.

Reset
REQ-023 rst=0 at any time SHALL immediately force, without waiting for clk:
- state IDLE, FIFO empty
- poseX=poseY=0, stepCount=0
- pass=fail=0, busy=0, moveReady=0
- captured target=0
REQ-024 Reset asserted mid-replay SHALL discard all in-flight moves; operation resumes only after rst=1 and a new start.
REQ-025 The first accepted start SHALL be the first rising edge with rst=1 and start=1.

Verification
REQ-026 Path pass: target (2,1); moves 00,00,01 with moveValid held high; then sqDone=1 -> pose (2,1), stepCount=3, pass=1, fail=0.
REQ-027 Underflow: target (0,0); move 10 -> pose stays (0,0), stepCount=0, fail=1 on the next edge.
REQ-028 Backpressure: moveValid=1 constantly and execution stalled -> after 4 accepts moveReady=0.
- Each pop re-raises moveReady; no move is lost or duplicated.
- 6 moves of 01 -> poseY=6.
REQ-029 Early sqDone: sqDone raised with 3 moves buffered -> DRAIN, busy=1, moveReady=0.
- Pass/fail is resolved exactly 3 edges later.
REQ-030 Wrong target: target (3,3); moves 00,01; sqDone -> pose (1,1), fail=1.
REQ-031 Async reset: rst=0 mid-RUN, between clock edges -> pose, stepCount, busy and FIFO are cleared immediately.
- After rst=1, start is required before moveReady=1.
